// File: rtl/tlbelo_csr_bank.sv
// TLBELO CSR bank: NUM_LO page-entry-low registers, masked CSR writes, and a
// TLBRD loader that fills every register from one TLB array response.
module tlbelo_csr_bank #(
  parameter int PALEN       = 32,
  parameter int NUM_LO      = 2,
  parameter int RSP_TIMEOUT = 16,
  localparam int SW = (NUM_LO > 2) ? $clog2(NUM_LO) : 1,
  localparam int PW = PALEN - 12
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   i_csr_we,
  input  logic [SW-1:0]          i_csr_wsel,
  input  logic [31:0]            i_csr_wmask,
  input  logic [31:0]            i_csr_wdata,
  output logic                   o_csr_wr_ready,
  input  logic [SW-1:0]          i_csr_rsel,
  output logic [31:0]            o_csr_rdata,
  input  logic                   i_tlbrd_req,
  output logic                   o_tlbrd_busy,
  input  logic                   i_tlb_rsp_valid,
  input  logic                   i_tlb_rsp_hit,
  input  logic [NUM_LO*PW-1:0]   i_tlb_rsp_ppn,
  input  logic [NUM_LO*6-1:0]    i_tlb_rsp_flags,
  input  logic                   i_tlb_rsp_g,
  output logic                   o_tlbrd_done,
  output logic                   o_tlbrd_err,
  output logic [NUM_LO*32-1:0]   o_elo_q
);

  typedef enum logic {ST_IDLE, ST_WAIT} state_t;

  // Writable bits: V, D, PLV, MAT, G and PPN; bit 7 and everything above PPN stay 0.
  localparam logic [31:0] LP_WMASK    = ((32'h1 << (PALEN - 4)) - 32'h1) & ~32'h80;
  localparam logic [7:0]  LP_TMO_LAST = 8'(RSP_TIMEOUT - 1);

  state_t      r_state;
  state_t      w_state_next;
  logic [7:0]  r_cnt;
  logic [7:0]  w_cnt_next;
  logic        r_done;
  logic        r_err;
  logic        w_done_next;
  logic        w_err_next;
  logic        w_load;
  logic        w_clear;
  logic        w_wr_en;
  logic [31:0] w_wmask;
  logic [31:0] r_elo      [NUM_LO];
  logic [31:0] w_rsp_word [NUM_LO];

  function automatic logic [31:0] f_pack(input logic [PW-1:0] ppn,
                                         input logic [5:0]    flags,
                                         input logic          g);
    logic [31:0] v;
    v              = '0;
    v[PALEN-5:8]   = ppn;
    v[6]           = g;
    v[5:0]         = flags;
    return v;
  endfunction

  assign o_csr_wr_ready = (r_state == ST_IDLE);
  assign o_tlbrd_busy   = (r_state == ST_WAIT);
  assign o_tlbrd_done   = r_done;
  assign o_tlbrd_err    = r_err;
  assign w_wmask        = i_csr_wmask & LP_WMASK;
  assign w_wr_en        = i_csr_we && o_csr_wr_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      r_done  <= w_done_next;
      r_err   <= w_err_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_done_next  = 1'b0;
    w_err_next   = 1'b0;
    w_load       = 1'b0;
    w_clear      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (i_tlbrd_req) begin
          w_state_next = ST_WAIT;
          w_cnt_next   = '0;
        end
      end
      ST_WAIT: begin
        w_cnt_next = r_cnt + 8'd1;
        // A response in the last timeout cycle still wins over the timeout.
        if (i_tlb_rsp_valid) begin
          w_state_next = ST_IDLE;
          w_done_next  = 1'b1;
          w_load       = i_tlb_rsp_hit;
          w_clear      = !i_tlb_rsp_hit;
        end else if (r_cnt == LP_TMO_LAST) begin
          w_state_next = ST_IDLE;
          w_done_next  = 1'b1;
          w_err_next   = 1'b1;
          w_clear      = 1'b1;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_LO; gi++) begin : g_lo
      assign w_rsp_word[gi] = f_pack(i_tlb_rsp_ppn[gi*PW +: PW],
                                     i_tlb_rsp_flags[gi*6 +: 6], i_tlb_rsp_g);
      assign o_elo_q[gi*32 +: 32] = r_elo[gi];
    end
  endgenerate

  // Load/clear only happen in WAIT and writes only in IDLE, so they never collide.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_LO; i++) r_elo[i] <= '0;
    end else if (w_load) begin
      for (int i = 0; i < NUM_LO; i++) r_elo[i] <= w_rsp_word[i];
    end else if (w_clear) begin
      for (int i = 0; i < NUM_LO; i++) r_elo[i] <= '0;
    end else if (w_wr_en) begin
      for (int i = 0; i < NUM_LO; i++) begin
        if (i_csr_wsel == SW'(i))
          r_elo[i] <= (r_elo[i] & ~w_wmask) | (i_csr_wdata & w_wmask);
      end
    end
  end

  // Out-of-range read indices return 0.
  always_comb begin
    o_csr_rdata = '0;
    for (int i = 0; i < NUM_LO; i++) begin
      if (i_csr_rsel == SW'(i)) o_csr_rdata = r_elo[i];
    end
  end

endmodule
